// File: rtl/display_scan_ctrl_pkg.sv
// display_pkg: shared scan-controller types, defaults and the hex-to-segment table.
package display_pkg;
  localparam int NUM_DIGITS_DEF = 8;
  typedef enum logic {BLANK, SHOW} scan_state_t;
  // Active-low {g,f,e,d,c,b,a} patterns, entry 0 at the right-hand end.
  localparam logic [15:0][6:0] SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/display_scan_ctrl_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low seven-segment pattern.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TBL[nib];
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: double-buffered multiplexed refresh of a seven-segment display.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS      = NUM_DIGITS_DEF,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  output logic [SW-1:0]           digit_sel,
  output logic                    blank,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    pending,
  output logic                    frame_tick
);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  scan_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [4*NUM_DIGITS-1:0] stg_dig, sh_dig, sh_dig_nx;
  logic [NUM_DIGITS-1:0] stg_dp, stg_en, sh_dp, sh_en, sh_dp_nx, sh_en_nx;
  logic [SW-1:0] sel_nx;
  logic blank_end, slot_end, wrap, commit;
  logic [6:0] seg;
  assign blank_end = state == BLANK && cnt == CW'(BLANK_TICKS - 1);
  assign slot_end  = state == SHOW && cnt == CW'(TICKS_PER_DIGIT - 1);
  assign sel_nx    = digit_sel == SW'(NUM_DIGITS - 1) ? '0 : digit_sel + 1'b1;
  assign wrap      = slot_end && sel_nx == '0;
  assign commit    = wrap && (load || pending);
  // A load on the commit edge bypasses staging so it is visible from slot 0.
  assign sh_dig_nx = commit ? (load ? digits_in : stg_dig) : sh_dig;
  assign sh_dp_nx  = commit ? (load ? dp_in : stg_dp) : sh_dp;
  assign sh_en_nx  = commit ? (load ? en_in : stg_en) : sh_en;
  hex_to_seg u_dec (.nib(sh_dig_nx[4*sel_nx +: 4]), .seg(seg));
  always_comb state_nx = blank_end ? SHOW : slot_end ? BLANK : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BLANK;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit_sel  <= '0;
      blank      <= 1'b1;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      stg_dig    <= '0;
      stg_dp     <= '0;
      stg_en     <= '0;
      sh_dig     <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_tick <= wrap;
      pending    <= wrap ? 1'b0 : load ? 1'b1 : pending;
      if (load) {stg_dig, stg_dp, stg_en} <= {digits_in, dp_in, en_in};
      {sh_dig, sh_dp, sh_en} <= {sh_dig_nx, sh_dp_nx, sh_en_nx};
      // Cathodes only move while anodes are off, at the start of each slot.
      if (slot_end) begin
        digit_sel <= sel_nx;
        blank     <= 1'b1;
        seg_n     <= sh_en_nx[sel_nx] ? seg : 7'h7F;
        dp_n      <= ~(sh_en_nx[sel_nx] & sh_dp_nx[sel_nx]);
      end else if (blank_end) begin
        blank <= ~sh_en[digit_sel];
      end
    end
  end
endmodule
